// File: rtl/aes_sbox_dom_sched.sv
// aes_sbox_dom_sched: round-robin scheduler feeding one shared pipelined DOM-masked AES S-box,
// gating issue on fresh randomness and tagging each byte with its requester ID through the pipe.
module aes_sbox_dom_sched #(
   parameter int d    = 2,
   parameter int NREQ = 4,
   parameter int LAT  = 2,
   parameter int RZW  = 18,
   parameter int RBW  = 8,
   localparam int W   = 8 * d,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic              rnd_valid,
   input  logic [RZW-1:0]    rnd_z,
   input  logic [RBW-1:0]    rnd_b,
   output logic              rnd_ready,
   output logic [W-1:0]      sbox_in,
   output logic [RZW-1:0]    sbox_rz,
   output logic [RBW-1:0]    sbox_rb,
   input  logic [W-1:0]      sbox_out,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   output logic              busy,
   output logic              err_rnd
);
   logic [IDW-1:0]          ptr_q, ptr_d, g, ci;
   logic                    gnt, err_q, err_d;
   logic [LAT-1:0]          vld_q;
   logic [LAT-1:0][IDW-1:0] id_q;
   // Scan from ptr upward with wrap; the lowest offset that is requesting wins.
   always_comb begin
      g   = '0;
      ci  = '0;
      gnt = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         ci = IDW'((int'(ptr_q) + k) % NREQ);
         if (req_valid[ci]) begin
            g   = ci;
            gnt = 1'b1;
         end
      end
      gnt   = gnt & rnd_valid & rst_n;
      ptr_d = gnt ? ((g == IDW'(NREQ - 1)) ? '0 : g + 1'b1) : ptr_q;
      err_d = err_q | (busy & ~rnd_valid);
   end
   assign req_ready = gnt ? NREQ'(1) << g : '0;
   assign sbox_in   = gnt ? req_data[int'(g)*W +: W] : '0;
   assign sbox_rz   = rnd_z;
   assign sbox_rb   = rnd_b;
   assign busy      = |vld_q;
   assign rnd_ready = rnd_valid & (gnt | busy);
   assign rsp_valid = vld_q[LAT-1];
   assign rsp_id    = id_q[LAT-1];
   assign rsp_data  = sbox_out;
   assign err_rnd   = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         err_q <= 1'b0;
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         err_q    <= err_d;
         vld_q[0] <= gnt;
         id_q[0]  <= g;
         for (int k = 1; k < LAT; k++) begin
            vld_q[k] <= vld_q[k-1];
            id_q[k]  <= id_q[k-1];
         end
      end
   end
endmodule

// File: tb/tb_aes_sbox_dom_sched.sv
// tb_aes_sbox_dom_sched: directed and randomized bench with a transaction-level reference model
// and a behavioural masked S-box standing in for aes_sbox_dom.
module tb_aes_sbox_dom_sched;
   localparam int D = 2, NREQ = 4, LAT = 2, RZW = 18, RBW = 8, W = 8 * D, IDW = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [NREQ*W-1:0] req_data;
   logic              rnd_valid, rnd_ready, rsp_valid, busy, err_rnd;
   logic [RZW-1:0]    rnd_z, sbox_rz;
   logic [RBW-1:0]    rnd_b, sbox_rb;
   logic [W-1:0]      sbox_in, sbox_out, rsp_data;
   logic [IDW-1:0]    rsp_id;
   always #5 clk = ~clk;
   aes_sbox_dom_sched #(.d(D), .NREQ(NREQ), .LAT(LAT), .RZW(RZW), .RBW(RBW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rnd_valid(rnd_valid), .rnd_z(rnd_z), .rnd_b(rnd_b), .rnd_ready(rnd_ready),
      .sbox_in(sbox_in), .sbox_rz(sbox_rz), .sbox_rb(sbox_rb), .sbox_out(sbox_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .err_rnd(err_rnd));
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   // AES S-box from its definition: GF(2^8) inverse then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      for (int n = 1; n < 5; n++) s ^= (inv << n) | (inv >> (8 - n));
      return s ^ 8'h63;
   endfunction
   function automatic logic [7:0] unmask(input logic [W-1:0] v);
      logic [7:0] r = 8'h00;
      for (int b = 0; b < 8; b++) for (int s = 0; s < D; s++) r[b] ^= v[b*D+s];
      return r;
   endfunction
   function automatic logic [W-1:0] mask(input logic [7:0] x, input logic [31:0] rnd);
      logic [7:0] sh [D];
      logic [W-1:0] v;
      sh[0] = x;
      for (int s = 1; s < D; s++) begin
         sh[s] = rnd[8*(s-1) +: 8];
         sh[0] ^= sh[s];
      end
      for (int b = 0; b < 8; b++) for (int s = 0; s < D; s++) v[b*D+s] = sh[s][b];
      return v;
   endfunction
   // Stand-in S-box: LAT-cycle pipe with fresh output remasking each cycle.
   logic [W-1:0] sp [LAT];
   always @(posedge clk) begin
      sp[0] <= mask(sbox(unmask(sbox_in)), $urandom);
      for (int k = 1; k < LAT; k++) sp[k] <= sp[k-1];
   end
   assign sbox_out = sp[LAT-1];
   typedef struct {int id; logic [7:0] b; int due;} ent_t;
   ent_t q[$];
   int errs = 0, checks = 0, m_ptr = 0, cyc = 0, last_g = -1, issues = 0;
   bit m_err = 1'b0;
   logic [NREQ-1:0] rq_v = '0;
   logic [7:0]      rq_b [NREQ];
   logic [W-1:0]    rq_vec [NREQ];
   logic            rv = 1'b0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask
   function automatic int exp_grant();
      if (!rv) return -1;
      for (int k = 0; k < NREQ; k++) if (rq_v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction
   task automatic set_req(input int i, input logic [7:0] x, input logic [31:0] m);
      rq_b[i] = x;
      rq_vec[i] = mask(x, m);
   endtask
   task automatic step();
      int g;
      bit be;
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = rq_vec[i];
      req_valid = rq_v;
      rnd_valid = rv;
      rnd_z = RZW'($urandom);
      rnd_b = RBW'($urandom);
      #1;
      g = exp_grant();
      be = q.size() > 0;
      chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1) << g : 32'd0);
      chk("rnd_ready", 32'(rnd_ready), 32'(rv && (g >= 0 || be)));
      chk("sbox_in", 32'(sbox_in), (g >= 0) ? 32'(rq_vec[g]) : 32'd0);
      chk("rnd_pass", {6'd0, sbox_rb, sbox_rz}, {6'd0, rnd_b, rnd_z});
      chk("busy", 32'(busy), 32'(be));
      chk("err_rnd", 32'(err_rnd), 32'(m_err));
      if (be && q[0].due == cyc) begin
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
         chk("rsp_xor", 32'(unmask(rsp_data)), 32'(sbox(q[0].b)));
         void'(q.pop_front());
      end else chk("rsp_valid", 32'(rsp_valid), 32'd0);
      if (g >= 0) begin
         q.push_back('{g, rq_b[g], cyc + LAT});
         m_ptr = (g + 1) % NREQ;
         issues++;
      end
      if (be && !rv) m_err = 1'b1;
      last_g = g;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '1;
      rnd_valid = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_err", 32'(err_rnd), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      m_ptr = 0;
      m_err = 1'b0;
      last_g = -1;
   endtask
   task automatic rand_reqs(input bit fixed);
      for (int i = 0; i < NREQ; i++) if (!rq_v[i] || last_g == i) begin
         rq_v[i] = 1'($urandom_range(0, 1));
         set_req(i, fixed ? 8'h3C : 8'($urandom), $urandom);
      end
      rv = $urandom_range(0, 9) != 0;
   endtask
   initial begin
      for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, 32'h0);
      do_reset();
      // single byte 0x00 split as 0x5A/0x5A
      set_req(0, 8'h00, 32'h5A);
      rq_v = 4'b0001; rv = 1'b1;
      step();
      rq_v = '0;
      repeat (LAT + 1) step();
      // all four continuously
      set_req(0, 8'h00, $urandom); set_req(1, 8'h01, $urandom);
      set_req(2, 8'h53, $urandom); set_req(3, 8'hFF, $urandom);
      rq_v = 4'b1111;
      repeat (9) step();
      rq_v = '0;
      repeat (LAT + 1) step();
      // fairness between 0 and 2
      rq_v = 4'b0101;
      repeat (6) step();
      rq_v = '0;
      repeat (LAT + 1) step();
      // randomness starvation and sticky error
      rq_v = 4'b1111; rv = 1'b0;
      repeat (2) step();
      rv = 1'b1;
      step();
      rv = 1'b0;
      repeat (3) step();
      rv = 1'b1;
      repeat (4) step();
      do_reset();
      // reset with LAT bytes in flight
      rq_v = 4'b1111; rv = 1'b1;
      repeat (LAT) step();
      do_reset();
      rq_v = '0;
      repeat (LAT + 2) step();
      // random traffic
      repeat (400) begin
         rand_reqs(1'b0);
         step();
      end
      do_reset();
      // same byte under many random share splits
      rq_v = '0; issues = 0;
      for (int n = 0; n < 5000 && issues < 1000; n++) begin
         rand_reqs(1'b1);
         step();
      end
      chk("issue_budget", 32'(issues >= 1000), 32'd1);
      rq_v = '0;
      repeat (LAT + 2) step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
